alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared, externally supplied ALU
package riscv_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_ops_t;
endpackage

module alu_arbiter #(
   parameter bit FAIR_RR = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [31:0]         req0_a,
   input  logic [31:0]         req0_b,
   input  riscv_pkg::alu_ops_t req0_op,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [31:0]         req1_a,
   input  logic [31:0]         req1_b,
   input  riscv_pkg::alu_ops_t req1_op,
   output logic                rsp0_valid,
   input  logic                rsp0_ready,
   output logic                rsp1_valid,
   input  logic                rsp1_ready,
   output logic [31:0]         rsp_result,
   output logic                rsp_zero,
   output logic [31:0]         alu_a,
   output logic [31:0]         alu_b,
   output riscv_pkg::alu_ops_t alu_ctrl,
   input  logic [31:0]         alu_result,
   input  logic                alu_zero,
   output logic [31:0]         ops_done
);
   import riscv_pkg::*;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_id_q, grant_id_d;
   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   alu_ops_t    alu_ctrl_q, alu_ctrl_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        rsp_zero_q, rsp_zero_d;
   logic [31:0] ops_done_q, ops_done_d;
   logic        grant_valid;
   logic        grant;

   // Contention goes to whoever did not win last time (round-robin) or to requester 0.
   always_comb begin
      grant_valid = req0_valid || req1_valid;
      if (req0_valid && req1_valid) begin
         grant = FAIR_RR ? ~last_grant_q : 1'b0;
      end else begin
         grant = req1_valid;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      ops_done_d   = ops_done_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               req0_ready   = ~grant;
               req1_ready   = grant;
               grant_id_d   = grant;
               last_grant_d = grant;
               alu_a_d      = grant ? req1_a : req0_a;
               alu_b_d      = grant ? req1_b : req0_b;
               alu_ctrl_d   = grant ? req1_op : req0_op;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            state_d      = RESP;
         end
         RESP: begin
            rsp0_valid = ~grant_id_q;
            rsp1_valid = grant_id_q;
            if (grant_id_q ? rsp1_ready : rsp0_ready) begin
               ops_done_d = ops_done_q + 32'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Handshake outputs stay quiet for the whole reset cycle so nothing is accepted or delivered.
      if (rst) begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
         rsp0_valid = 1'b0;
         rsp1_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         alu_a_q      <= 32'd0;
         alu_b_q      <= 32'd0;
         alu_ctrl_q   <= ALU_ADD;
         rsp_result_q <= 32'd0;
         rsp_zero_q   <= 1'b0;
         ops_done_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign ops_done   = ops_done_q;
endmodule
